wfrm_source_arbiter: RTL
========================

Name: wfrm_source_arbiter

Overview:
- Packet-granular arbiter that shares the single waveform_formatter input (wfrm_axis_*) between two AXI-Stream waveform sources (host-loaded waveform path and local BRAM replay path).
- Validates the leading command word of every packet against the waveform command constant. Forwards valid packets intact; drops malformed ones up to and including their tlast.
- Sits directly upstream of waveform_formatter, in the axi_tclk domain.

Parameters:
- DATA_WIDTH, 32, tdata width of all streams.
- WFRM_CMD, 32'h57574441, required value of beat 0 of every packet.
- CNT_WIDTH, 16, width of the per-port packet counters and the drop counter.

Ports:
- axi_tclk  in  1  clock
- axi_treset  in  1  synchronous reset, active-high
- s0_axis_tdata  in  DATA_WIDTH  source 0 data
- s0_axis_tvalid  in  1  source 0 valid
- s0_axis_tlast  in  1  source 0 end of packet
- s0_axis_tkeep  in  DATA_WIDTH/8  source 0 byte keep
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tdata / tvalid / tlast / tkeep / tready  (same widths)  source 1, identical semantics
- m_axis_tdata  out  DATA_WIDTH  to formatter wfrm_axis_tdata
- m_axis_tvalid  out  1  to formatter
- m_axis_tlast  out  1  to formatter
- m_axis_tkeep  out  DATA_WIDTH/8  to formatter
- m_axis_tready  in  1  from formatter wfrm_axis_tready
- grant  out  1  currently/last granted source
- busy  out  1  state != IDLE
- pkt_count0  out  CNT_WIDTH  packets forwarded from source 0
- pkt_count1  out  CNT_WIDTH  packets forwarded from source 1
- drop_count  out  CNT_WIDTH  packets dropped for bad command word

Behaviour:
- Reset: state=IDLE, grant=1 (so source 0 wins first contention), all counters 0, s*_tready=0, m_axis_tvalid=0. busy=0.
- Datapath is combinational muxing on registered grant/state; no data registers, so latency is 0 cycles once granted.
- m_axis_tdata/tlast/tkeep follow the granted source at all times. m_axis_tvalid is gated as listed per state.
- The non-granted source's tready is always 0.
- IDLE:
  - All treadys = 0, m_axis_tvalid=0.
  - Only s0 valid: grant<=0. Only s1 valid: grant<=1.
  - Both valid: grant<=~grant (round robin).
  - Any valid -> HDR next cycle. One dead cycle per packet.
- HDR (beat 0 of the granted packet):
  - cmd_ok = (granted tdata == WFRM_CMD).
  - cmd_ok=1: m_axis_tvalid = granted tvalid; granted tready = m_axis_tready.
  - cmd_ok=0: m_axis_tvalid=0; granted tready=1 (sink).
  - On handshake with cmd_ok=1: tlast=1 -> IDLE and increment pkt_count[grant]; tlast=0 -> FWD.
  - On handshake with cmd_ok=0: increment drop_count; tlast=1 -> IDLE; tlast=0 -> DROP.
- FWD:
  - m_axis_tvalid = granted tvalid; granted tready = m_axis_tready.
  - On the tlast handshake: pkt_count[grant]++ and -> IDLE.
- DROP:
  - granted tready=1, m_axis_tvalid=0.
  - On tlast with tvalid -> IDLE.
  - Beats are discarded regardless of m_axis_tready.
- Grant never changes outside IDLE; a packet is never interleaved with another.
- Backpressure: m_axis_tready low in HDR/FWD stalls the source with no beat lost or duplicated. tdata stability is the source's obligation.
- Counters saturate at all-ones; they do not wrap.
- A single-beat packet (tlast on beat 0) is legal in both HDR outcomes.
- Reset asserted mid-packet: immediate return to reset values next edge. The remainder of the interrupted packet is treated as a new packet, so its next beat is header-checked and normally dropped.
- tvalid deasserting mid-packet is legal; state holds.

Optional Feature:
- Macro: WFRM_FIXED_PRIO_EN.
- Defined: IDLE contention always grants source 0. Reset value of grant is 0. Source 1 is served only when s0_axis_tvalid=0 in IDLE.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then s0 sends 8 beats (beat0=32'h57574441, tlast on beat 7), m_axis_tready=1 -> 8 beats on m_axis in order with tlast on 8th; pkt_count0=1; 1 dead cycle before HDR.
- s0 and s1 both valid with good 4-beat packets, continuously -> m_axis alternates s0,s1,s0,s1; after 4 packets pkt_count0=2, pkt_count1=2. With WFRM_FIXED_PRIO_EN, only s0 packets appear while s0 stays valid.
- s1 packet with beat0=32'hDEADBEEF, 6 beats -> no m_axis_tvalid; s1_axis_tready=1 for all 6 beats; drop_count=1; next good s1 packet forwarded.
- m_axis_tready toggled 1/0 every cycle during a 256-beat packet -> exactly 256 output beats, data matches input sequence, no duplicates, s0_axis_tready mirrors m_axis_tready.
- Assert axi_treset at beat 3 of a 10-beat s0 packet -> next cycle all outputs at reset values; resumed beats are dropped (drop_count=1) until tlast; the following good packet is forwarded.
- Preload drop_count near saturation via 65536 single-beat bad packets (CNT_WIDTH=16) -> drop_count holds 16'hFFFF.

Source files
------------

// File: rtl/wfrm_source_arbiter.sv
// rtl/wfrm_source_arbiter.sv - packet-granular two-source arbiter with command-word check (opt: WFRM_FIXED_PRIO_EN)
module wfrm_source_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] WFRM_CMD   = 32'h57574441,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                    axi_tclk,
    input  logic                    axi_treset,
    input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
    input  logic                    s0_axis_tvalid,
    input  logic                    s0_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0] s0_axis_tkeep,
    output logic                    s0_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
    input  logic                    s1_axis_tvalid,
    input  logic                    s1_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0] s1_axis_tkeep,
    output logic                    s1_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    input  logic                    m_axis_tready,
    output logic                    grant,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    pkt_count0,
    output logic [CNT_WIDTH-1:0]    pkt_count1,
    output logic [CNT_WIDTH-1:0]    drop_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef WFRM_FIXED_PRIO_EN
    localparam logic GRANT_RST = 1'b0;
`else
    localparam logic GRANT_RST = 1'b1;
`endif

    typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

    state_t state;
    logic   grant_q;
    logic   sel_tvalid;
    logic   sel_tlast;
    logic   sel_tready;
    logic   cmd_ok;
    logic   xfer;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    assign grant        = grant_q;
    assign busy         = (state != IDLE);
    assign m_axis_tdata = grant_q ? s1_axis_tdata : s0_axis_tdata;
    assign m_axis_tkeep = grant_q ? s1_axis_tkeep : s0_axis_tkeep;
    assign m_axis_tlast = grant_q ? s1_axis_tlast : s0_axis_tlast;
    assign sel_tvalid   = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_tlast    = m_axis_tlast;
    assign cmd_ok       = (m_axis_tdata == WFRM_CMD);

    // Bad headers are sunk locally so the source can drain without the formatter seeing them.
    always_comb begin
        m_axis_tvalid = 1'b0;
        sel_tready    = 1'b0;
        case (state)
            HDR: begin
                if (cmd_ok) begin
                    m_axis_tvalid = sel_tvalid;
                    sel_tready    = m_axis_tready;
                end else begin
                    sel_tready    = 1'b1;
                end
            end
            FWD: begin
                m_axis_tvalid = sel_tvalid;
                sel_tready    = m_axis_tready;
            end
            DROP:    sel_tready = 1'b1;
            default: sel_tready = 1'b0;
        endcase
    end

    assign s0_axis_tready = ~grant_q & sel_tready;
    assign s1_axis_tready =  grant_q & sel_tready;
    assign xfer           = sel_tvalid & sel_tready;

    always_ff @(posedge axi_tclk) begin
        if (axi_treset) begin
            state      <= IDLE;
            grant_q    <= GRANT_RST;
            pkt_count0 <= '0;
            pkt_count1 <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        state <= HDR;
`ifdef WFRM_FIXED_PRIO_EN
                        grant_q <= ~s0_axis_tvalid;
`else
                        if (s0_axis_tvalid && s1_axis_tvalid) grant_q <= ~grant_q;
                        else                                  grant_q <= ~s0_axis_tvalid;
`endif
                    end
                end
                HDR: begin
                    if (xfer) begin
                        if (cmd_ok) begin
                            if (sel_tlast) begin
                                state <= IDLE;
                                if (grant_q) pkt_count1 <= sat_inc(pkt_count1);
                                else         pkt_count0 <= sat_inc(pkt_count0);
                            end else begin
                                state <= FWD;
                            end
                        end else begin
                            drop_count <= sat_inc(drop_count);
                            state      <= sel_tlast ? IDLE : DROP;
                        end
                    end
                end
                FWD: begin
                    if (xfer && sel_tlast) begin
                        state <= IDLE;
                        if (grant_q) pkt_count1 <= sat_inc(pkt_count1);
                        else         pkt_count0 <= sat_inc(pkt_count0);
                    end
                end
                DROP: begin
                    if (xfer && sel_tlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
